pearson8_dec: RTL and testbench
===============================

Name: pearson8_dec

Overview:
- Receive-side counterpart of pearson8_rtl.
- Takes the running 8-bit Pearson hash stream produced by the hasher, one hash per character, and recovers the original characters.
- Recovery relation: c[n] = Tinv[h[n]] ^ h[n-1], with h[-1] = 8'h00 at each init.
- The inverse permutation Tinv is built internally after reset from the team's shared forward table (function pearson8_tab(i) in pearson8_tab.svh, the same table used by pearson8_rtl).

Parameters:
- BUILD_START, 8'h00, first index the table-build counter visits after reset; build always covers all 256 entries and wraps.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  hash_in/init sampled this cycle when high and ready=1.
- init  input  1  hash_in is the first hash of a new word; previous hash taken as 8'h00.
- hash_in  input  8  running hash value from the hasher.
- ready  output  1  inverse table built; block accepts input.
- char_valid  output  1  char_out holds a newly recovered character this cycle.
- char_out  output  8  recovered character.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0, as follows.
  - ready=0, char_valid=0, char_out=8'h00.
  - prev_hash=8'h00, build counter=BUILD_START.
  - state=BUILD.
  - Inverse RAM contents are not reset; they are don't-care until rebuilt.
- State BUILD:
  - Each cycle writes inv[pearson8_tab(cnt)] = cnt, then cnt = cnt+1 (8-bit wrap).
  - After exactly 256 writes (counter returns to BUILD_START), go to READY the next cycle.
  - ready rises exactly 256 cycles after reset deassertion.
  - enable, init and hash_in are ignored; char_valid stays 0.
- State READY:
  - ready=1.
  - On a cycle with enable=1:
    - char_out <= inv[hash_in] ^ (init ? 8'h00 : prev_hash).
    - prev_hash <= hash_in.
    - char_valid <= 1.
  - On a cycle with enable=0: char_valid <= 0; char_out and prev_hash hold.
- Latency: one clock, from the sampling edge to char_valid/char_out.
- Throughput: one character per clock; back-to-back enable is supported.
- init with enable=0 has no effect; prev_hash is kept.
- Reset mid-BUILD or mid-stream:
  - Asynchronously returns to BUILD and clears prev_hash.
  - Full 256-cycle rebuild follows.
- No other states. READY is terminal until the next reset.
- Inverse RAM:
  - 256x8, written only in BUILD, read combinationally in READY.
  - May be inferred as distributed RAM.

Optional Feature:
- Macro: PEARSON8_DEC_PRINTABLE_EN.
- Defined:
  - Adds output port bad_char (1 bit, reset 0).
  - bad_char is sticky. It sets on the same edge that char_valid is set with a recovered character outside 8'h20..8'h7E.
  - It clears only on reset.
- Undefined: no bad_char port and no associated logic.

Test Plan:
- Build timing:
  - Release reset, hold enable=1 throughout.
  - Required: ready=0 for exactly 256 clocks, then 1.
  - Required: char_valid=0 throughout the build.
- Single word " test":
  - Drive the hashes pearson8_rtl produces for 8'h20, 8'h74, 8'h65, 8'h73, 8'h74, with init=1 on the first.
  - Required: char_out = 20,74,65,73,74 with char_valid=1, each one clock after its input.
- Back-to-back words:
  - Repeat the 5-character sequence three times with init on each 8'h20 hash.
  - Required: identical character stream each pass; prev_hash is cleared by each init.
- Gaps:
  - Insert enable=0 cycles between characters.
  - Required: char_valid=0 in the gaps, char_out holds, and the next character is still recovered correctly.
- Reset mid-stream:
  - Assert reset during the third character.
  - Required: all outputs 0 immediately; after 256 clocks ready=1; the stream restarted with init decodes correctly.
- PEARSON8_DEC_PRINTABLE_EN:
  - Drive hash pearson8_tab(8'h07) with init=1.
  - Required: char_out=8'h07, and bad_char=1 from that edge until reset.
  - Printable-only streams keep bad_char=0.

Source files
------------

// File: rtl/pearson8_dec.sv
// Pearson-hash stream decoder: rebuilds the inverse of the shared forward table after reset,
// then recovers c[n] = Tinv[h[n]] ^ h[n-1]. Optional sticky bad_char via PEARSON8_DEC_PRINTABLE_EN.
module pearson8_dec #(
    parameter logic [7:0] BUILD_START = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       init,
    input  logic [7:0] hash_in,
    output logic       ready,
    output logic       char_valid,
    output logic [7:0] char_out
`ifdef PEARSON8_DEC_PRINTABLE_EN
    ,
    output logic       bad_char
`endif
);

    // Shared forward permutation, kept in step with the pearson8_rtl hasher.
    function automatic logic [7:0] pearson8_tab(input logic [7:0] i);
        return {i[4:0], i[7:5]} ^ 8'h5A;
    endfunction

    typedef enum logic {
        S_BUILD,
        S_READY
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] r_prev;
    logic [7:0] r_inv [256];
    logic [7:0] w_char;
    logic       w_accept;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == S_BUILD) begin
            w_cnt_next = r_cnt + 8'd1;
            if (w_cnt_next == BUILD_START) begin
                w_next_state = S_READY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_BUILD;
            r_cnt   <= BUILD_START;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // No reset on the table so it can map onto distributed RAM.
    always_ff @(posedge clock) begin
        if (r_state == S_BUILD) begin
            r_inv[pearson8_tab(r_cnt)] <= r_cnt;
        end
    end

    assign ready    = (r_state == S_READY);
    assign w_accept = ready && enable;
    assign w_char   = r_inv[hash_in] ^ (init ? 8'h00 : r_prev);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            char_valid <= 1'b0;
            char_out   <= 8'h00;
            r_prev     <= 8'h00;
        end else if (w_accept) begin
            char_valid <= 1'b1;
            char_out   <= w_char;
            r_prev     <= hash_in;
        end else begin
            char_valid <= 1'b0;
        end
    end

`ifdef PEARSON8_DEC_PRINTABLE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bad_char <= 1'b0;
        end else if (w_accept && ((w_char < 8'h20) || (w_char > 8'h7E))) begin
            bad_char <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pearson8_dec.sv
// Directed bench for pearson8_dec; hash vectors for " test" hand-computed from the forward table.
// Exercises bad_char as well when PEARSON8_DEC_PRINTABLE_EN is defined.
module tb_pearson8_dec;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       init;
    logic [7:0] hashIn;
    logic       ready;
    logic       charValid;
    logic [7:0] charOut;
`ifdef PEARSON8_DEC_PRINTABLE_EN
    logic       badChar;
`endif

    int checks = 0;
    int errors = 0;

    // Hashes of 0x20,0x74,0x65,0x73,0x74 starting from h=0x00.
    logic [7:0] wordHash [5] = '{8'h5B, 8'h23, 8'h68, 8'h82, 8'hED};
    logic [7:0] wordChar [5] = '{8'h20, 8'h74, 8'h65, 8'h73, 8'h74};

    pearson8_dec dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .init       (init),
        .hash_in    (hashIn),
        .ready      (ready),
        .char_valid (charValid),
        .char_out   (charOut)
`ifdef PEARSON8_DEC_PRINTABLE_EN
        ,
        .bad_char   (badChar)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [7:0] expChar);
        checkVal({tag, ".ready"}, {7'd0, ready}, 8'h01);
        checkVal({tag, ".valid"}, {7'd0, charValid}, {7'd0, expValid});
        checkVal({tag, ".char"}, charOut, expChar);
    endtask

    // Drive on the falling edge, return 1 time unit after the following rising edge.
    task automatic applyStimulus(input logic en, input logic ini, input logic [7:0] h);
        @(negedge clock);
        enable = en;
        init   = ini;
        hashIn = h;
        @(posedge clock);
        #1;
    endtask

    task automatic releaseAndBuild(input string tag);
        enable = 1'b1;
        init   = 1'b1;
        hashIn = 8'hFF;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clock);
            #1;
            checkVal({tag, ".buildReady"}, {7'd0, ready}, (i == 256) ? 8'h01 : 8'h00);
            checkVal({tag, ".buildValid"}, {7'd0, charValid}, 8'h00);
        end
    endtask

    task automatic sendWord(input string tag);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, k == 0, wordHash[k]);
            checkOutput(tag, 1'b1, wordChar[k]);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        init   = 1'b0;
        hashIn = 8'h00;
        #23;
        $display("[TB] reset state");
        checkVal("rst.ready", {7'd0, ready}, 8'h00);
        checkVal("rst.valid", {7'd0, charValid}, 8'h00);
        checkVal("rst.char", charOut, 8'h00);
`ifdef PEARSON8_DEC_PRINTABLE_EN
        checkVal("rst.bad", {7'd0, badChar}, 8'h00);
`endif

        $display("[TB] build timing");
        releaseAndBuild("build1");

        $display("[TB] single word");
        sendWord("word1");
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle", 1'b0, 8'h74);

        $display("[TB] back-to-back words");
        for (int p = 0; p < 3; p++) begin
            sendWord("b2b");
        end

        $display("[TB] gaps");
        applyStimulus(1'b1, 1'b1, wordHash[0]);
        checkOutput("gap.c0", 1'b1, 8'h20);
        for (int k = 1; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h99);
            checkOutput("gap.hold", 1'b0, wordChar[k-1]);
            applyStimulus(1'b0, 1'b0, 8'h33);
            checkOutput("gap.hold2", 1'b0, wordChar[k-1]);
            applyStimulus(1'b1, 1'b0, wordHash[k]);
            checkOutput("gap.ck", 1'b1, wordChar[k]);
        end

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b1, wordHash[0]);
        checkOutput("mid.c0", 1'b1, 8'h20);
        applyStimulus(1'b1, 1'b0, wordHash[1]);
        checkOutput("mid.c1", 1'b1, 8'h74);
        @(negedge clock);
        hashIn = wordHash[2];
        #2;
        reset = 1'b0;
        #1;
        checkVal("mid.rstReady", {7'd0, ready}, 8'h00);
        checkVal("mid.rstValid", {7'd0, charValid}, 8'h00);
        checkVal("mid.rstChar", charOut, 8'h00);
        @(posedge clock);
        #1;
        checkVal("mid.holdReady", {7'd0, ready}, 8'h00);
        releaseAndBuild("build2");
        sendWord("restart");

`ifdef PEARSON8_DEC_PRINTABLE_EN
        $display("[TB] printable check");
        checkVal("bad.clean", {7'd0, badChar}, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h62);
        checkOutput("bad.c07", 1'b1, 8'h07);
        checkVal("bad.set", {7'd0, badChar}, 8'h01);
        sendWord("bad.after");
        checkVal("bad.sticky", {7'd0, badChar}, 8'h01);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkVal("bad.rst", {7'd0, badChar}, 8'h00);
        releaseAndBuild("build3");
        sendWord("bad.word");
        checkVal("bad.printable", {7'd0, badChar}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
